// File: rtl/aa_fetch_sched_pkg.sv
// Shared types for the anti-aliasing fetch scheduler: FSM states, kernel tap
// identifiers and the tap-sequencing helper.
package aa_pkg;

  localparam int AA_TAP_NUM = 5;
  localparam int AA_TAP_W   = $clog2(AA_TAP_NUM);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} aa_sched_state_e;

  // Declaration order is the read order on the frame RAM port.
  typedef enum logic [AA_TAP_W-1:0] {TAP_C, TAP_N, TAP_S, TAP_W, TAP_E} aa_tap_e;

  // Next tap in read order; saturates at the last tap.
  function automatic aa_tap_e aa_next_tap(input aa_tap_e tap);
    return (tap == TAP_E) ? TAP_E : aa_tap_e'(tap + AA_TAP_W'(1));
  endfunction

endpackage

// File: rtl/aa_fetch_sched_if.sv
// Frame RAM read port plus the neighbourhood bundle handed to the AA datapath.
// master = scheduler side, slave = RAM / filter side.
interface aa_fetch_sched_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data;
  logic              px_valid;
  logic              px_ready;
  logic [PIX_W-1:0]  px_c;
  logic [PIX_W-1:0]  px_n;
  logic [PIX_W-1:0]  px_s;
  logic [PIX_W-1:0]  px_w;
  logic [PIX_W-1:0]  px_e;
  logic              px_border;
  logic [ADDR_W-1:0] px_addr;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output px_valid,
    input  px_ready,
    output px_c, px_n, px_s, px_w, px_e, px_border, px_addr
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  px_valid,
    output px_ready,
    input  px_c, px_n, px_s, px_w, px_e, px_border, px_addr
  );
endinterface

// File: rtl/aa_fetch_sched_raster_cnt.sv
// Raster position counter: row/col/linear address of the current centre pixel,
// with frame-edge flags and the last-pixel flag. The linear address steps by
// one per pixel, so no multiplier is needed.
module aa_raster_cnt #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_top,
  output logic              o_bot,
  output logic              o_left,
  output logic              o_right,
  output logic              o_border,
  output logic              o_last
);
  localparam int ROW_W = $clog2(FRAME_H);
  localparam int COL_W = $clog2(FRAME_W);

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;

  // Step one pixel in raster order; column wrap carries into the row.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_advance) begin
      r_addr <= r_addr + 1'b1;
      if (r_col == COL_W'(FRAME_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_addr   = r_addr;
  assign o_top    = (r_row == '0);
  assign o_bot    = (r_row == ROW_W'(FRAME_H - 1));
  assign o_left   = (r_col == '0);
  assign o_right  = (r_col == COL_W'(FRAME_W - 1));
  assign o_border = o_top | o_bot | o_left | o_right;
  assign o_last   = o_bot & o_right;
endmodule

// File: rtl/aa_fetch_sched.sv
// Fetch scheduler for the 5-point AA kernel. Walks the frame in raster order,
// time-shares the single frame RAM read port over taps C,N,S,W,E and presents
// each neighbourhood on a valid/ready bundle.
// Optional feature macro: AA_BORDER_CLAMP_EN -- border pixels also do the full
// five-read fetch with edge-replicated (clamped) taps. Without it, border
// pixels read only the centre and replicate it into all taps.
module aa_fetch_sched
  import aa_pkg::*;
#(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            frame_cnt,
  aa_fetch_sched_if.master       bus
);
  aa_sched_state_e   r_state;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_frame_cnt;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  aa_tap_e           r_rd_tap;
  logic              r_cap_vld;
  aa_tap_e           r_cap_tap;
  logic              r_px_valid;
  logic              r_px_border;
  logic [ADDR_W-1:0] r_px_addr;

  logic [ADDR_W-1:0] w_addr;
  logic              w_top, w_bot, w_left, w_right, w_border, w_last;
  logic              w_clear, w_advance;
  aa_tap_e           w_next_tap;
  aa_tap_e           w_final_tap;
  logic [ADDR_W-1:0] w_tap_addr;
  logic [PIX_W-1:0]  w_tap [AA_TAP_NUM];

  assign w_clear    = (r_state == IDLE) && start;
  assign w_advance  = (r_state == ISSUE) && bus.px_ready && !w_last;
  assign w_next_tap = aa_next_tap(r_rd_tap);

  aa_raster_cnt #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .ADDR_W  (ADDR_W)
  ) u_raster (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_top     (w_top),
    .o_bot     (w_bot),
    .o_left    (w_left),
    .o_right   (w_right),
    .o_border  (w_border),
    .o_last    (w_last)
  );

`ifdef AA_BORDER_CLAMP_EN
  assign w_final_tap = TAP_E;
`else
  assign w_final_tap = w_border ? TAP_C : TAP_E;
`endif

  // Address of the next tap as a constant offset from the centre; an edge tap
  // falls back to the centre, which is the clamped coordinate and also keeps
  // N/W from underflowing on row 0 / col 0.
  always_comb begin
    w_tap_addr = w_addr;
    case (w_next_tap)
      TAP_N:   if (!w_top)   w_tap_addr = w_addr - ADDR_W'(FRAME_W);
      TAP_S:   if (!w_bot)   w_tap_addr = w_addr + ADDR_W'(FRAME_W);
      TAP_W:   if (!w_left)  w_tap_addr = w_addr - 1'b1;
      TAP_E:   if (!w_right) w_tap_addr = w_addr + 1'b1;
      default: w_tap_addr = w_addr;
    endcase
  end

  // Scheduler FSM: read sequencing, issue handshake and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_tap    <= TAP_C;
      r_cap_vld   <= 1'b0;
      r_cap_tap   <= TAP_C;
      r_px_valid  <= 1'b0;
      r_px_border <= 1'b0;
      r_px_addr   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cap_vld <= r_rd_en;
      r_cap_tap <= r_rd_tap;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= FETCH;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_rd_tap  <= TAP_C;
          end
        end
        FETCH: begin
          if (r_rd_en) begin
            if (r_rd_tap == w_final_tap) begin
              r_rd_en <= 1'b0;
            end else begin
              r_rd_tap  <= w_next_tap;
              r_rd_addr <= w_tap_addr;
            end
          end
          if (r_cap_vld && (r_cap_tap == w_final_tap)) begin
            r_state     <= ISSUE;
            r_px_valid  <= 1'b1;
            r_px_border <= w_border;
            r_px_addr   <= w_addr;
          end
        end
        ISSUE: begin
          if (bus.px_ready) begin
            r_px_valid <= 1'b0;
            if (w_last) begin
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end else begin
              // Raster order makes the next centre simply addr+1.
              r_state   <= FETCH;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_addr + 1'b1;
              r_rd_tap  <= TAP_C;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // One capture register per tap; the centre read seeds every tap so border
  // pass-through needs no extra reads.
  for (genvar gi = 0; gi < AA_TAP_NUM; gi++) begin : g_tap
    logic [PIX_W-1:0] r_val;

    // Load this tap when its read data (or the centre's) returns.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_val <= '0;
      end else if (r_cap_vld &&
                   ((r_cap_tap == TAP_C) || (r_cap_tap == aa_tap_e'(AA_TAP_W'(gi))))) begin
        r_val <= bus.mem_rd_data;
      end
    end

    assign w_tap[gi] = r_val;
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign frame_cnt       = r_frame_cnt;
  assign bus.mem_rd_en   = r_rd_en;
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.px_valid    = r_px_valid;
  assign bus.px_c        = w_tap[TAP_C];
  assign bus.px_n        = w_tap[TAP_N];
  assign bus.px_s        = w_tap[TAP_S];
  assign bus.px_w        = w_tap[TAP_W];
  assign bus.px_e        = w_tap[TAP_E];
  assign bus.px_border   = r_px_border;
  assign bus.px_addr     = r_px_addr;
endmodule

// File: tb/tb_aa_fetch_sched.sv
// Bench for aa_fetch_sched on a 4x3 frame with a registered-read RAM model.
// Expected taps, border flags and per-pixel timing come from coordinate
// arithmetic on the frame, not from the scheduler's internal sequencing.
module tb_aa_fetch_sched;
  localparam int FW = 4;
  localparam int FH = 3;
  localparam int PW = 8;
  localparam int AW = 4;
  localparam int NPIX = FW * FH;
  localparam int M_RDY = 0, M_STALL = 1, M_RAND = 2, M_RESET = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  aa_fetch_sched_if #(.PIX_W(PW), .ADDR_W(AW)) mif ();

  aa_fetch_sched #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .PIX_W   (PW),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .bus       (mif)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] ram [0:15];

  always @(posedge clk) begin
    if (mif.mem_rd_en) mif.mem_rd_data <= ram[mif.mem_rd_addr];
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_idx, hs_prev, start_ref, stall_px, exp_frames;
  bit          prev_stall, finished;
  logic [63:0] snap_prev;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_border(input int idx);
    int r = idx / FW;
    int c = idx % FW;
    return (r == 0) || (r == FH - 1) || (c == 0) || (c == FW - 1);
  endfunction

  // Address of kernel tap t (0=C,1=N,2=S,3=W,4=E) for raster pixel idx.
  function automatic int tap_addr(input int idx, input int t);
    int r = idx / FW;
    int c = idx % FW;
`ifndef AA_BORDER_CLAMP_EN
    if (is_border(idx)) return idx;
`endif
    case (t)
      1:       return ((r == 0) ? 0 : r - 1) * FW + c;
      2:       return ((r == FH - 1) ? r : r + 1) * FW + c;
      3:       return r * FW + ((c == 0) ? 0 : c - 1);
      4:       return r * FW + ((c == FW - 1) ? c : c + 1);
      default: return idx;
    endcase
  endfunction

  function automatic int pix_cost(input int idx);
`ifdef AA_BORDER_CLAMP_EN
    return 7;
`else
    return is_border(idx) ? 3 : 7;
`endif
  endfunction

  function automatic int frame_cycles();
    int sum = 1;
    for (int i = 0; i < NPIX; i++) sum += pix_cost(i);
    return sum;
  endfunction

  function automatic logic any_out();
    return |{busy, done, frame_cnt, mif.mem_rd_en, mif.mem_rd_addr, mif.px_valid,
             mif.px_c, mif.px_n, mif.px_s, mif.px_w, mif.px_e, mif.px_border, mif.px_addr};
  endfunction

  // Observe one cycle (called at the falling edge after inputs are set).
  task automatic monitor();
    logic [63:0] snap;
    bit          stall_now;
    snap = {19'd0, mif.px_c, mif.px_n, mif.px_s, mif.px_w, mif.px_e, mif.px_border, mif.px_addr};
    stall_now = mif.px_valid && !mif.px_ready;
    if (mif.px_valid && mif.px_ready) begin
      if (m_idx >= NPIX) begin
        check_val("px_extra", m_idx, NPIX - 1);
      end else begin
        check_val("px_c", mif.px_c, ram[tap_addr(m_idx, 0)]);
        check_val("px_n", mif.px_n, ram[tap_addr(m_idx, 1)]);
        check_val("px_s", mif.px_s, ram[tap_addr(m_idx, 2)]);
        check_val("px_w", mif.px_w, ram[tap_addr(m_idx, 3)]);
        check_val("px_e", mif.px_e, ram[tap_addr(m_idx, 4)]);
        check_val("px_border", mif.px_border, is_border(m_idx));
        check_val("px_addr", mif.px_addr, m_idx);
        check_val("px_gap", cyc - hs_prev, pix_cost(m_idx) + stall_px);
        check_val("busy_hs", busy, 1);
      end
      hs_prev  = cyc;
      stall_px = 0;
      m_idx++;
    end
    if (stall_now) begin
      stall_px++;
      check_val("rd_in_stall", mif.mem_rd_en, 0);
      if (prev_stall) check_val("hold", snap, snap_prev);
    end
    prev_stall = stall_now;
    snap_prev  = snap;
    if (done) begin
      check_val("done_npix", m_idx, NPIX);
      check_val("done_lat", cyc - hs_prev, 1);
      check_val("frame_cnt", frame_cnt, exp_frames);
      check_val("busy_at_done", busy, 0);
      finished = 1;
    end
  endtask

  task automatic run_frame(input int mode);
    int stall_left = 10;
    bit fired = 0;
    int done_cyc = 0;
    start      = 1'b1;
    start_ref  = cyc;
    hs_prev    = cyc;
    m_idx      = 0;
    stall_px   = 0;
    prev_stall = 0;
    finished   = 0;
    exp_frames++;
    for (int n = 0; n < 2000 && !finished; n++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      case (mode)
        M_STALL: begin
          mif.px_ready = 1'b1;
          if (mif.px_valid && m_idx == 5 && stall_left > 0) begin
            mif.px_ready = 1'b0;
            stall_left--;
          end
          if (m_idx == 3 && !fired) begin
            start = 1'b1;
            fired = 1;
          end
          if (done) start = 1'b1;
        end
        M_RAND:  mif.px_ready = 1'($urandom_range(0, 1));
        M_RESET: begin
          mif.px_ready = 1'($urandom_range(0, 1));
          if (m_idx == 7 && !fired) begin
            reset = 1'b1;
            fired = 1;
          end
        end
        default: mif.px_ready = 1'b1;
      endcase
      if (reset) finished = 1;
      else monitor();
      if (finished) done_cyc = cyc;
    end
    check_val("frame_done", finished, 1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
    if (mode == M_RDY) check_val("frame_cycles", done_cyc - start_ref, frame_cycles());
    if (mode == M_RESET) begin
      reset = 1'b0;
      check_val("rst_out", any_out(), 0);
      exp_frames = 0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    mif.px_ready = 1'b0;
    exp_frames   = 0;
    for (int i = 0; i < 16; i++) ram[i] = PW'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("por_out", any_out(), 0);
    reset = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_val("idle_out", any_out(), 0);

    run_frame(M_RDY);
    run_frame(M_STALL);
    repeat (5) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_val("idle_after_done_start", {busy, mif.px_valid, mif.mem_rd_en}, 0);

    run_frame(M_RESET);
    run_frame(M_RDY);
    for (int i = 0; i < 16; i++) ram[i] = PW'($urandom);
    run_frame(M_RAND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
